// File: rtl/uart_rx_word32_pkg.sv
// Shared definitions for the 8N1 UART link: byte FSM states and bit-timing helpers.
package uart_rx_word32_pkg;

    // Byte receiver FSM states
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    // Start + 8 data + stop
    localparam int unsigned FRAME_BITS = 10;

    // Clocks per bit; integer division, matches the transmitter side
    function automatic int unsigned calc_cpb(input int unsigned clk_hz,
                                             input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Offset from the start edge to the middle of the start bit
    function automatic int unsigned calc_half_cpb(input int unsigned clk_hz,
                                                  input int unsigned bit_rate);
        return calc_cpb(clk_hz, bit_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_word32_byte.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling FSM, byte and framing-error pulses.
module uart_rx_byte
    import uart_rx_word32_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 500000,
    parameter int unsigned BIT_RATE = 9600
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_busy,
    output logic       o_start,     // start edge seen this cycle
    output logic       o_accept,    // good stop bit this cycle; o_byte_valid follows
    output logic       o_reject,    // bad stop bit this cycle; o_frame_err follows
    output logic [7:0] o_shift      // assembled data bits, complete while in StStop
);

    localparam int unsigned CPB  = calc_cpb(CLK_HZ, BIT_RATE);
    localparam int unsigned HALF = calc_half_cpb(CLK_HZ, BIT_RATE);
    localparam int unsigned CW   = $clog2(CPB + 1);

    logic       r_sync1;
    logic       r_sync2;
    rx_state_e  r_state;
    rx_state_e  w_state_d;
    logic [CW-1:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic [7:0] r_byte;
    logic       r_byte_valid;
    logic       r_frame_err;

    logic w_rxs;
    logic w_tick;
    logic w_half;
    logic w_start;
    logic w_sample;
    logic w_accept;
    logic w_reject;

    assign w_rxs  = r_sync2;
    // r_cnt equals the number of cycles since the last timing reference
    assign w_tick = (r_cnt == CW'(CPB));

    // Two-flop synchroniser, idles high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    // FSM next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (!w_rxs) w_state_d = StStart;
            StStart: if (r_cnt == CW'(HALF)) w_state_d = w_rxs ? StIdle : StData;
            StData:  if (w_tick && r_bit == 3'd7) w_state_d = StStop;
            StStop:  if (w_tick) w_state_d = w_rxs ? StIdle : StBreak;
            StBreak: if (w_rxs) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // FSM decoded strobes
    always_comb begin
        w_start  = (r_state == StIdle) && !w_rxs;
        w_half   = (r_state == StStart) && (r_cnt == CW'(HALF));
        w_sample = (r_state == StData) && w_tick;
        w_accept = (r_state == StStop) && w_tick && w_rxs;
        w_reject = (r_state == StStop) && w_tick && !w_rxs;
    end

    // Bit timer, data shifter and registered output pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= w_accept;
            r_frame_err  <= w_reject;
            if (w_start || w_half || w_sample) begin
                r_cnt <= CW'(1);
            end else if (r_state == StStart || r_state == StData || r_state == StStop) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_start) r_bit <= '0;
            else if (w_sample) r_bit <= r_bit + 3'd1;
            if (w_sample) r_shift <= {w_rxs, r_shift[7:1]};
            if (w_accept) r_byte <= r_shift;
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = (r_state != StIdle);
    assign o_start      = w_start;
    assign o_accept     = w_accept;
    assign o_reject     = w_reject;
    assign o_shift      = r_shift;

endmodule

// File: rtl/uart_rx_word32.sv
// UART receiver that packs four consecutive bytes, LSB first, into 32-bit words,
// with an inter-byte timeout that drops a stale partial word.
module uart_rx_word32
    import uart_rx_word32_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 500000,
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_uart_rxd,
    output logic [7:0]  o_byte_out,
    output logic        o_byte_valid,
    output logic [31:0] o_word_out,
    output logic        o_word_valid,
    output logic        o_frame_err,
    output logic        o_timeout,
    output logic        o_busy
);

    localparam int unsigned CPB    = calc_cpb(CLK_HZ, BIT_RATE);
    localparam int unsigned TO_CYC = TIMEOUT_BITS * CPB;
    localparam int unsigned TW     = $clog2(TO_CYC + 1);

    logic        w_start;
    logic        w_accept;
    logic        w_reject;
    logic        w_busy;
    logic [7:0]  w_shift;
    logic        w_to_fire;

    logic [1:0]    r_byte_cnt;
    logic [23:0]   r_acc;
    logic [31:0]   r_word;
    logic          r_word_valid;
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;

    uart_rx_byte #(
        .CLK_HZ   (CLK_HZ),
        .BIT_RATE (BIT_RATE)
    ) u_byte (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_rxd        (i_uart_rxd),
        .o_byte       (o_byte_out),
        .o_byte_valid (o_byte_valid),
        .o_frame_err  (o_frame_err),
        .o_busy       (w_busy),
        .o_start      (w_start),
        .o_accept     (w_accept),
        .o_reject     (w_reject),
        .o_shift      (w_shift)
    );

    // A start edge on the terminal count suppresses the timeout
    assign w_to_fire = !w_busy && (r_byte_cnt != 2'd0) && !w_start
                       && (r_to_cnt == TW'(TO_CYC - 1));

    // Word assembly; word pulse is aligned with the 4th byte pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt   <= '0;
            r_acc        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                unique case (r_byte_cnt)
                    2'd0: r_acc[7:0]   <= w_shift;
                    2'd1: r_acc[15:8]  <= w_shift;
                    2'd2: r_acc[23:16] <= w_shift;
                    2'd3: begin
                        r_word       <= {w_shift, r_acc};
                        r_word_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (w_reject || w_to_fire) begin
                r_byte_cnt <= '0;
            end
        end
    end

    // Inter-byte idle timer, only live with a partial word and an idle line
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            if (w_busy || r_byte_cnt == 2'd0 || w_start || w_to_fire) r_to_cnt <= '0;
            else r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign o_word_out   = r_word;
    assign o_word_valid = r_word_valid;
    assign o_timeout    = r_timeout;
    assign o_busy       = w_busy;

endmodule
